// File: rtl/uart_result_tx_pkg.sv
// Shared definitions for the UART result transmit sequencer.
package uart_result_tx_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StWait = 2'd2
    } state_e;

    // Bytes per frame: header, result, checksum.
    localparam int unsigned FRAME_LEN = 3;
    localparam int unsigned IDX_W     = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [7:0] HEADER_DEF = 8'hA5;

endpackage

// File: rtl/uart_result_tx_if.sv
// Handshake bundle between the ALU/receive side, the sequencer and the UART TX core.
interface uart_result_tx_if #(
    parameter int unsigned NB_BITS = 8
);
    logic               i_start;
    logic [NB_BITS-1:0] i_result;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_BITS-1:0] o_tx_data;
    logic               o_busy;
    logic               o_overrun;

    // Environment side: issues requests and TX-done pulses.
    modport master (
        output i_start, i_result, i_tx_done,
        input  o_tx_start, o_tx_data, o_busy, o_overrun
    );

    // Sequencer side.
    modport slave (
        input  i_start, i_result, i_tx_done,
        output o_tx_start, o_tx_data, o_busy, o_overrun
    );
endinterface

// File: rtl/uart_result_tx_result_slot.sv
// One-deep holding register for a request that arrives while a frame is in flight.
module uart_result_tx_result_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             take_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Load wins over take so a simultaneous take+load leaves the slot refilled.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (take_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    // Slot storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign full_o  = valid_q;
endmodule

// File: rtl/uart_result_tx.sv
// Sends each ALU result as a HEADER/RESULT/CHECKSUM frame through the UART TX core.
module uart_result_tx
    import uart_result_tx_pkg::*;
#(
    parameter int unsigned        NB_BITS = 8,
    parameter logic [NB_BITS-1:0] HEADER  = NB_BITS'(HEADER_DEF)
) (
    input logic             clk,
    input logic             reset,
    uart_result_tx_if.slave bus
);
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_BITS-1:0] act_q, act_d;
    logic [NB_BITS-1:0] tx_data_q, tx_data_d;
    logic               overrun_q, overrun_d;

    logic               slot_load, slot_take;
    logic [NB_BITS-1:0] slot_data;
    logic               slot_valid, slot_full;
    logic               final_done;

    function automatic logic [NB_BITS-1:0] frame_byte(input logic [NB_BITS-1:0] res,
                                                      input logic [IDX_W-1:0]   idx);
        case (idx)
            2'd0:    return HEADER;
            2'd1:    return res;
            default: return HEADER ^ res;
        endcase
    endfunction

    uart_result_tx_result_slot #(
        .WIDTH (NB_BITS)
    ) u_pend (
        .clk     (clk),
        .reset   (reset),
        .load_i  (slot_load),
        .take_i  (slot_take),
        .data_i  (bus.i_result),
        .data_o  (slot_data),
        .valid_o (slot_valid),
        .full_o  (slot_full)
    );

    // State, byte index, active result, held TX byte and overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            act_q     <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            act_q     <= act_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: frame sequencing plus routing of requests into act or the pending slot.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        act_d      = act_q;
        slot_load  = 1'b0;
        slot_take  = 1'b0;
        overrun_d  = 1'b0;
        final_done = (state_q == StWait) && bus.i_tx_done && (idx_q == LAST_IDX);

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    act_d   = bus.i_result;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: state_d = StWait;
            StWait: begin
                if (bus.i_tx_done) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StSend;
                    end else if (slot_valid) begin
                        act_d     = slot_data;
                        slot_take = 1'b1;
                        idx_d     = '0;
                        state_d   = StSend;
                    end else if (bus.i_start) begin
                        // Nothing queued: the new request goes straight to act.
                        act_d   = bus.i_result;
                        idx_d   = '0;
                        state_d = StSend;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Mid-frame request: queue it unless the slot stays occupied this cycle.
        if (bus.i_start && (state_q != StIdle) && !(final_done && !slot_valid)) begin
            if (!slot_full || slot_take) begin
                slot_load = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Outputs; the TX byte is latched only on the edge that enters SEND.
    always_comb begin
        bus.o_tx_start = (state_q == StSend);
        bus.o_busy     = (state_q != StIdle) | slot_valid;
        bus.o_tx_data  = tx_data_q;
        bus.o_overrun  = overrun_q;
        tx_data_d      = tx_data_q;
        if (state_d == StSend) begin
            tx_data_d = frame_byte(act_d, idx_d);
        end
    end
endmodule

// File: tb/tb_uart_result_tx.sv
// Randomised scoreboard bench for uart_result_tx with a frame-level reference model.
module tb_uart_result_tx;
    localparam int unsigned NB  = 8;
    localparam logic [7:0]  HDR = 8'hA5;

    typedef struct {
        logic start;
        logic busy;
        logic ovr;
        logic rst;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_result_tx_if #(.NB_BITS(NB)) bus ();

    uart_result_tx #(
        .NB_BITS (NB),
        .HEADER  (HDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rec_t       exp_q[$];
    logic [7:0] byte_q[$];
    int         checks   = 0;
    int         failures = 0;

    // Reference model: frames accepted but not yet finished, and dones seen in the current frame.
    int         outstanding = 0;
    int         dcount      = 0;
    int         cnt         = 0;
    int         lat_lo      = 10;
    int         lat_hi      = 10;
    bit         arm_sim     = 1'b0;
    logic [7:0] sim_res     = 8'h00;
    bit         flush       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs for the coming edge and predict its outcome.
    task automatic cycle(input bit s_in, input logic [7:0] r_in, input bit rst, input bit force_done);
        bit         s, d, fin, acc, ns;
        logic [7:0] r;
        int         oa;
        rec_t       rec;
        @(posedge clk);
        #1;
        if (flush) begin
            byte_q.delete();
            flush = 1'b0;
        end
        d = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) d = 1'b1;
        end
        if (bus.o_tx_start === 1'b1) cnt = $urandom_range(lat_lo, lat_hi);
        d = d | force_done;
        s = s_in;
        r = r_in;
        if (arm_sim && d && dcount == 2 && outstanding == 1) begin
            s       = 1'b1;
            r       = sim_res;
            arm_sim = 1'b0;
        end
        if (rst) begin
            s   = 1'b0;
            d   = 1'b0;
            cnt = 0;
        end
        reset         = rst;
        bus.i_start   = s;
        bus.i_result  = r;
        bus.i_tx_done = d;
        if (rst) begin
            outstanding = 0;
            dcount      = 0;
            flush       = 1'b1;
            rec         = '{1'b0, 1'b0, 1'b0, 1'b1};
        end else begin
            fin = 1'b0;
            if (d && outstanding > 0) begin
                dcount++;
                if (dcount == 3) begin
                    dcount = 0;
                    fin    = 1'b1;
                end
            end
            oa  = outstanding - int'(fin);
            acc = s && (oa < 2);
            if (acc) begin
                byte_q.push_back(HDR);
                byte_q.push_back(r);
                byte_q.push_back(HDR ^ r);
            end
            ns = (d && outstanding > 0 && !fin) || (fin && (oa + int'(acc)) > 0) ||
                 (outstanding == 0 && acc);
            outstanding = oa + int'(acc);
            rec = '{ns, outstanding > 0, s && !acc, 1'b0};
        end
        exp_q.push_back(rec);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] r);
        cycle(1'b1, r, 1'b0, 1'b0);
    endtask

    // Monitor: compares each cycle's outputs against the predicted record and byte stream.
    logic [7:0] prev_data;
    bit         have_prev = 1'b0;
    always @(negedge clk) begin
        rec_t e;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            chk("tx_start", 32'(bus.o_tx_start), 32'(e.start));
            chk("busy", 32'(bus.o_busy), 32'(e.busy));
            chk("overrun", 32'(bus.o_overrun), 32'(e.ovr));
            if (e.rst) begin
                chk("tx_data_reset", 32'(bus.o_tx_data), 32'h0);
            end else if (have_prev && bus.o_tx_start !== 1'b1) begin
                chk("tx_data_hold", 32'(bus.o_tx_data), 32'(prev_data));
            end
            if (bus.o_tx_start === 1'b1) begin
                if (byte_q.size() == 0) begin
                    chk("tx_byte_unexpected", 32'(bus.o_tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", 32'(bus.o_tx_data), 32'(byte_q.pop_front()));
                end
            end
            prev_data = bus.o_tx_data;
            have_prev = 1'b1;
        end
    end

    initial begin
        bus.i_start   = 1'b0;
        bus.i_result  = '0;
        bus.i_tx_done = 1'b0;
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // Single frame and boundary results, fixed 10-cycle TX latency.
        send(8'h3C);
        idle(40);
        send(8'h00);
        idle(40);
        send(8'hFF);
        idle(40);

        // Pending request mid-frame, then back-to-back frames.
        send(8'h11);
        idle(5);
        send(8'h22);
        idle(80);

        // Third request while active and pending are both occupied.
        send(8'h11);
        idle(3);
        send(8'h22);
        idle(3);
        send(8'h33);
        idle(80);

        // Request coincident with the final done, nothing pending.
        send(8'h55);
        sim_res = 8'h44;
        arm_sim = 1'b1;
        idle(80);
        arm_sim = 1'b0;

        // Reset mid-frame with a pending request, stray done, then a clean frame.
        send(8'h66);
        idle(3);
        send(8'h77);
        idle(10);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);
        send(8'h01);
        idle(45);

        // Random traffic with random TX latency.
        lat_lo = 1;
        lat_hi = 12;
        repeat (1500) begin
            if (!arm_sim && $urandom_range(0, 15) == 0) begin
                arm_sim = 1'b1;
                sim_res = 8'($urandom);
            end
            cycle($urandom_range(0, 5) == 0, 8'($urandom), 1'b0, 1'b0);
        end
        arm_sim = 1'b0;
        idle(200);

        chk("bytes_drained", 32'(byte_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_result_tx.md
# uart_result_tx

Transmit-side sequencer for the UART ALU path. It captures the ALU result when the receive-side interface signals a completed operand/opcode set, then drives the UART transmitter byte-by-byte with a 3-byte frame: HEADER, RESULT, CHECKSUM. It sits between the ALU output and the UART TX core, handshaking on a one-cycle start pulse and a one-cycle done pulse. It holds one request pending while a frame is in flight.

## Interface

Parameters:
- NB_BITS, 8, width of result and of each UART byte
- HEADER, 8'hA5, first byte of every frame (NB_BITS wide)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- i_start  in  1  one-cycle request: send i_result (driven by the receive interface's tx_start)
- i_result  in  NB_BITS  ALU result; sampled only in the cycle i_start=1
- i_tx_done  in  1  one-cycle pulse from UART TX: current byte fully shifted out
- o_tx_start  out  1  one-cycle pulse to UART TX: load o_tx_data and transmit
- o_tx_data  out  NB_BITS  byte to transmit; stable from o_tx_start until next o_tx_start
- o_busy  out  1  high while a frame is in flight or a request is pending
- o_overrun  out  1  one-cycle pulse: request dropped (active and pending both occupied)

## Operation

- Frame: byte0 = HEADER, byte1 = result, byte2 = HEADER ^ result (bitwise XOR, NB_BITS wide, no carry).
- State register, 3 states: IDLE, SEND, WAIT. Byte index counter idx, 0..2. Active result register act. Pending slot pend + pend_valid.
- IDLE: i_start=1 → act ← i_result, idx ← 0, go SEND.
- SEND (exactly one cycle): o_tx_start=1, o_tx_data = byte[idx]; go WAIT.
- WAIT: hold o_tx_data; on i_tx_done:
  - idx<2 → idx ← idx+1, go SEND.
  - idx==2 and pend_valid → act ← pend, pend_valid ← 0, idx ← 0, go SEND.
  - idx==2, no pending → go IDLE.
- i_start while not IDLE: if pend_valid=0 → pend ← i_result, pend_valid ← 1; else drop, pulse o_overrun next cycle; act and pend unchanged.
- Simultaneous i_start with final i_tx_done (idx==2): pend_valid=0 → i_result loads directly into act, go SEND; pend_valid=1 → pend moves to act, i_result into pend (no overrun).
- i_tx_done outside WAIT ignored.
- o_busy = (state != IDLE) | pend_valid.

## Timing

- Reset values: state IDLE, idx 0, act 0, pend 0, pend_valid 0, o_tx_start 0, o_tx_data 0, o_busy 0, o_overrun 0.
- Reset mid-frame: abort immediately at the next edge, discard pending, no further o_tx_start.
- i_start sampled at edge k → o_tx_start high in cycle k+1, with o_tx_data = HEADER.
- i_tx_done sampled at edge k → next o_tx_start in cycle k+1 (one-cycle turnaround).
- o_tx_start never high on two consecutive cycles; never high in IDLE.
- o_tx_data changes only on the edge entering SEND.
- o_overrun is registered, one cycle after the offending i_start.

## Structure

- Shared package: state encodings (IDLE/SEND/WAIT), FRAME_LEN = 3, default HEADER value.
- Optional sub-module result_slot: one-deep holding register with load/take/valid and a full flag, used for pend. Everything else stays in the top module.

## Test plan

- Single frame: i_start with i_result=0x3C, TX model returns done 10 cycles after each start → bytes A5, 3C, 99; o_busy drops the cycle after the third done.
- Boundary values: results 0x00 and 0xFF → A5,00,A5 and A5,FF,5A; o_tx_start exactly 3 pulses per frame.
- Pending: i_start 0x11, then i_start 0x22 mid-frame → frames A5,11,B4 then A5,22,87 back-to-back; second header start one cycle after the first frame's last done.
- Overrun: 0x11 in flight, 0x22 pending, i_start 0x33 → o_overrun one pulse; only the 0x11 and 0x22 frames are sent.
- Simultaneous: i_start 0x44 coincident with the final i_tx_done, no pending → o_tx_start next cycle with A5, then 44, 0xE1; no overrun.
- Reset mid-frame: assert reset after byte1's o_tx_start, with a pending request → all outputs 0 next cycle; stray i_tx_done ignored; next i_start 0x01 sends A5,01,A4 cleanly.
